// File: rtl/rr_grant_sequencer_if.sv
// Grant bus between requesters and the round-robin grant sequencer.
// The master side drives requests and the release strobe. The slave side,
// which is the arbiter, returns the registered grant, the index and the timeout pulse.
interface rr_grant_sequencer_if;
    logic [7:0] req;        // level-sensitive request lines, bit i = requester i
    logic       done;       // owner release strobe
    logic       gnt_valid;  // grant active, gnt_idx valid while high
    logic [2:0] gnt_idx;    // binary index of the granted requester
    logic       timeout;    // one-cycle pulse: grant revoked by the hold limit

    modport master (
        output req,
        output done,
        input  gnt_valid,
        input  gnt_idx,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt_valid,
        output gnt_idx,
        output timeout
    );
endinterface

// File: rtl/rr_grant_sequencer.sv
// Round-robin grant sequencer for 8 requesters.
// The grant index and the valid strobe drive a downstream 3-to-8 one-hot decoder.
// The owner keeps a grant until it pulses done, drops its request, or reaches the
// optional hold limit. Each grant is followed by one forced IDLE cycle. That cycle
// gives break-before-make on the decoded one-hot lines.
module rr_grant_sequencer #(
    parameter int HOLD_MAX = 16,  // max grant length in cycles; 0 = unlimited
    // Derived width of the hold counter. Do not override.
    parameter int HOLD_W   = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_grant_sequencer_if.slave  bus
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    // Counter value at which the grant has been held for HOLD_MAX cycles.
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (HOLD_MAX > 0) ? HOLD_W'(HOLD_MAX - 1) : '0;
    localparam logic [HOLD_W-1:0] HOLD_SAT  = {HOLD_W{1'b1}};

    state_t            r_state;
    logic              r_gnt_valid;
    logic [2:0]        r_gnt_idx;
    logic              r_timeout;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [2:0]        r_last_idx;  // last granted index; lowest priority in the next search

    logic [2:0]        w_sel;
    logic [2:0]        w_cand;
    logic              w_any_req;
    logic              w_owner_rel;
    logic              w_limit;
    logic              w_release;

    // Round-robin pick: the first set request after r_last_idx, with wrap-around.
    // NOTE: every variable assigned in always_comb gets a default on entry. A path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        w_sel  = r_last_idx;
        w_cand = r_last_idx;
        // Scan from the farthest offset to the nearest. The nearest set bit is
        // written last, so it wins. Offset 8 wraps back to r_last_idx, which
        // therefore has the lowest priority.
        for (int off = 8; off >= 1; off--) begin
            w_cand = r_last_idx + 3'(off);
            if (bus.req[w_cand]) begin
                w_sel = w_cand;
            end
        end
    end

    // Release conditions while in GRANT: owner release, or the hold limit.
    always_comb begin
        w_any_req   = |bus.req;
        w_owner_rel = bus.done || !bus.req[r_gnt_idx];
        w_limit     = (HOLD_MAX != 0) && (r_hold_cnt == HOLD_LAST);
        w_release   = w_owner_rel || w_limit;
    end

    // IDLE/GRANT state machine. All outputs are registered here.
    // NOTE: sequential state uses non-blocking assignments only. All registers
    // then update together on the edge, and no register sees another's new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_gnt_valid <= 1'b0;
            r_gnt_idx   <= 3'd0;
            r_timeout   <= 1'b0;
            r_hold_cnt  <= '0;
            r_last_idx  <= 3'd7;  // so the first search starts at requester 0
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // done is ignored here. Only a pending request matters.
                    if (w_any_req) begin
                        r_state     <= S_GRANT;
                        r_gnt_valid <= 1'b1;
                        r_gnt_idx   <= w_sel;
                        r_last_idx  <= w_sel;
                        r_hold_cnt  <= '0;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        // Return to IDLE for a mandatory gap cycle. gnt_idx keeps its value.
                        r_state     <= S_IDLE;
                        r_gnt_valid <= 1'b0;
                        // Pulse timeout only when the hold limit alone ended the grant.
                        r_timeout   <= w_limit && !w_owner_rel;
                    end else if (r_hold_cnt != HOLD_SAT) begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt_valid = r_gnt_valid;
    assign bus.gnt_idx   = r_gnt_idx;
    assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Directed bench for rr_grant_sequencer.
// u_dut4 has HOLD_MAX=4 and covers reset, round-robin order, wrap, the hold
// limit and reset in mid-grant. u_dut0 has HOLD_MAX=0 and covers unlimited holding.
module tb_rr_grant_sequencer;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    rr_grant_sequencer_if u_if4 ();
    rr_grant_sequencer_if u_if0 ();

    rr_grant_sequencer #(.HOLD_MAX(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (u_if4)
    );

    rr_grant_sequencer #(.HOLD_MAX(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (u_if0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock. Drive and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check4(input string tag, input logic gv, input logic [2:0] idx, input logic to);
        check({tag, ".gnt_valid"}, u_if4.gnt_valid, gv);
        check({tag, ".gnt_idx"},   u_if4.gnt_idx,   idx);
        check({tag, ".timeout"},   u_if4.timeout,   to);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        u_if4.req = 8'h00; u_if4.done = 1'b0;
        u_if0.req = 8'h00; u_if0.done = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state on both instances.
        check4("rst4", 1'b0, 3'd0, 1'b0);
        check("rst0.gnt_valid", u_if0.gnt_valid, 1'b0);
        check("rst0.timeout",   u_if0.timeout,   1'b0);

        // T1: a single request is granted after one cycle, and done releases it.
        u_if4.req = 8'h01;
        tick();
        check4("t1_grant", 1'b1, 3'd0, 1'b0);
        u_if4.done = 1'b1;
        tick();
        check4("t1_release", 1'b0, 3'd0, 1'b0);
        u_if4.done = 1'b0;
        u_if4.req  = 8'h00;
        tick();
        check4("t1_idle", 1'b0, 3'd0, 1'b0);

        // T2: all requesting with done held high. The order is 0..7,0 with one idle cycle between grants.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        u_if4.req  = 8'hFF;
        u_if4.done = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check4($sformatf("t2_grant%0d", i), 1'b1, 3'(i % 8), 1'b0);
            tick();
            check4($sformatf("t2_gap%0d", i), 1'b0, 3'(i % 8), 1'b0);
        end
        u_if4.req  = 8'h00;
        u_if4.done = 1'b0;

        // T3: after a grant to 2, requests 0 and 1 are served with wrap-around, 0 first, then 1.
        u_if4.req = 8'h04;
        tick();
        check4("t3_grant2", 1'b1, 3'd2, 1'b0);
        u_if4.req = 8'h00;          // dropping the request releases the grant
        tick();
        check4("t3_drop", 1'b0, 3'd2, 1'b0);
        u_if4.req = 8'h03;
        tick();
        check4("t3_wrap0", 1'b1, 3'd0, 1'b0);
        u_if4.done = 1'b1;
        tick();
        check4("t3_rel0", 1'b0, 3'd0, 1'b0);
        u_if4.done = 1'b0;
        tick();
        check4("t3_next1", 1'b1, 3'd1, 1'b0);
        u_if4.req = 8'h00;
        tick();
        check4("t3_rel1", 1'b0, 3'd1, 1'b0);

        // T4: the hold limit revokes the grant after exactly 4 cycles, and 5 is granted again.
        u_if4.req = 8'h20;
        tick();
        check4("t4_c1", 1'b1, 3'd5, 1'b0);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check4($sformatf("t4_c%0d", i), 1'b1, 3'd5, 1'b0);
        end
        tick();
        check4("t4_timeout", 1'b0, 3'd5, 1'b1);
        tick();
        check4("t4_regrant", 1'b1, 3'd5, 1'b0);
        u_if4.req = 8'h00;
        tick();
        check4("t4_rel", 1'b0, 3'd5, 1'b0);

        // T5a: done on the 4th grant cycle coincides with the limit, so no timeout.
        u_if4.req = 8'h20;
        tick();
        check4("t5_c1", 1'b1, 3'd5, 1'b0);
        tick();
        tick();
        tick();
        check4("t5_c4", 1'b1, 3'd5, 1'b0);
        u_if4.done = 1'b1;
        tick();
        check4("t5_done_at_limit", 1'b0, 3'd5, 1'b0);
        u_if4.done = 1'b0;
        u_if4.req  = 8'h00;
        tick();
        check4("t5_idle", 1'b0, 3'd5, 1'b0);

        // T5b: reset in mid-grant clears the grant, and search restarts at 0.
        u_if4.req = 8'hFF;
        tick();
        check4("t5_grant6", 1'b1, 3'd6, 1'b0);
        rst = 1'b1;
        tick();
        check4("t5_rst_mid", 1'b0, 3'd0, 1'b0);
        rst = 1'b0;
        tick();
        check4("t5_after_rst", 1'b1, 3'd0, 1'b0);
        u_if4.req = 8'h00;
        tick();
        check4("t5_rel", 1'b0, 3'd0, 1'b0);

        // T6: with HOLD_MAX=0 the grant is held with no limit. Other req bits do not move it.
        u_if0.req = 8'h08;
        tick();
        check("t6_grant.gnt_valid", u_if0.gnt_valid, 1'b1);
        check("t6_grant.gnt_idx",   u_if0.gnt_idx,   3'd3);
        for (int i = 0; i < 100; i++) begin
            if (i == 50) u_if0.req = 8'hFF;
            tick();
            check($sformatf("t6_hold%0d.gnt_valid", i), u_if0.gnt_valid, 1'b1);
            check($sformatf("t6_hold%0d.gnt_idx", i),   u_if0.gnt_idx,   3'd3);
            check($sformatf("t6_hold%0d.timeout", i),   u_if0.timeout,   1'b0);
        end
        u_if0.req = 8'h00;
        tick();
        check("t6_rel.gnt_valid", u_if0.gnt_valid, 1'b0);
        check("t6_rel.timeout",   u_if0.timeout,   1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
